nibble_shift_out: RTL and testbench
===================================

# nibble_shift_out

- Serial readout engine for multi-nibble register values, for example a bank of 4-bit load registers or counter outputs.
- On a start request it captures a parallel word of `NIBBLES` 4-bit digits and shifts it out bit-serially on a clock/data/latch interface.
- This interface drives shift-register-based display and LED chains (74x164/74x595 style) on the board.
- It is the read side of the load registers: registers are written in parallel and this block reads them out serially.

## Interface
Parameters:
- `NIBBLES`, default 4: number of 4-bit digits per frame; B = 4*NIBBLES bits per frame; legal range 1..8.
- `DIV`, default 2: half-period of `sclk` in `clk` cycles; legal range ≥1.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  frame request; sampled only in IDLE.
- `data_in`  in  4*NIBBLES  parallel word; captured on an accepted start.
- `busy`  out  1  high while a frame is in flight (LOW/HIGH/LATCH).
- `done`  out  1  one-cycle pulse after a frame completes.
- `sclk`  out  1  serial clock; the receiver samples `sdat` on the rising edge of `sclk`.
- `sdat`  out  1  serial data.
- `slatch`  out  1  output-latch strobe to the receiver chain.

## Operation
- The state machine has five states: IDLE, LOW, HIGH, LATCH and DONE. All outputs are registered.
- **Reset:** `rst` high at an edge forces IDLE and clears the shift register and all counters. It also sets `busy`=`done`=`sclk`=`sdat`=`slatch`=0. This holds mid-frame: the frame is abandoned, no `done` pulse is produced, and `slatch` is never asserted for a partial frame.
- **IDLE:** when `start`=1, capture `data_in` into the shift register and load the bit counter with B. Go to LOW and present the first bit on `sdat`. `start` is ignored in every other state.
- **LOW:** `sclk`=0 and `sdat` is held stable for DIV cycles, then go to HIGH.
- **HIGH:** `sclk`=1 for DIV cycles, then:
  - decrement the bit counter;
  - if it is nonzero, shift, go to LOW and present the next bit;
  - otherwise go to LATCH.
- **LATCH:** `slatch`=1, `sclk`=0 and `sdat`=0 for DIV cycles, then go to DONE.
- **DONE:** `done`=1 and `busy`=0 for exactly one cycle, then go to IDLE. A `start` in DONE is not accepted, so back-to-back frames need `start` held or re-asserted in IDLE.
- **Bit order:** MSB first by default (bit 4*NIBBLES-1 first); see Configuration.
- **Input isolation:** changes on `data_in` after capture have no effect on the frame in flight.
- **Counter sizing:**
  - The divider counter is `$clog2(DIV+1)` bits wide and wraps to 0 at each phase change.
  - The bit counter is `$clog2(B+1)` bits wide.
  - No arithmetic overflow is possible within the legal parameter ranges.

## Timing
- Start accepted at edge k: `busy`=1, `sclk`=0 and `sdat`=first bit are visible after edge k.
- Each bit occupies 2*DIV cycles: DIV cycles low, then DIV cycles high.
- `slatch` is high for DIV cycles immediately after the last HIGH phase.
- `busy` stays high for DIV*(2B+1) cycles. The `done` pulse follows in the next cycle, and IDLE is reached one cycle after that.
- Start-to-start minimum is DIV*(2B+1)+2 cycles. For NIBBLES=4 and DIV=2 this is 66+2 = 68.
- All outputs are 0 in IDLE.

## Configuration
- Macro `NIBBLE_SHIFT_LSB_FIRST_EN`.
- **Defined:** frames go out LSB first (bit 0 first; shift right).
- **Undefined:** frames go out MSB first (shift left).
- The macro does not change timing, ports or any other behaviour.

## Structure
- A shared package `nibble_shift_pkg` holds:
  - the state enum typedef (IDLE, LOW, HIGH, LATCH, DONE);
  - the constant `NIBBLE_W`=4;
  - the default values for `NIBBLES` and `DIV`.
- One sub-module, `sclk_divider`, is natural: a DIV-cycle phase counter with a `tick` output. It restarts on a phase change and is cleared by `rst`.
- The FSM and the shift register stay in the top level.

## Test plan
- **Reset state:** `rst` high for 2 cycles → all outputs 0. Hold `start`=0 for 10 cycles → outputs remain 0.
- **MSB-first frame:** NIBBLES=4, DIV=2, `data_in`=16'hA5C3, `start` pulsed for 1 cycle.
  - Bits captured on `sclk` rising edges = 1010_0101_1100_0011.
  - `busy` high for 66 cycles, `slatch` high for 2 cycles, one `done` pulse at cycle 67.
- **LSB-first build:** same frame built with `NIBBLE_SHIFT_LSB_FIRST_EN` → captured bits = 1100_0011_1010_0101, with identical timing.
- **Ignored inputs mid-frame:**
  - `start` re-pulsed at cycle 20 of a frame → ignored, and exactly one `done` is produced.
  - `data_in` changed to 16'hFFFF mid-frame → the transmitted data is unchanged.
- **Reset mid-frame:** `rst` asserted at cycle 30 of a frame → all outputs 0 on the next edge, no `slatch` and no `done`. A subsequent `start` with 16'h0001 transmits correctly.
- **Minimum divider:** DIV=1, NIBBLES=1, `data_in`=4'h9, `start` held high continuously.
  - Each frame: bits 1001, `busy` for 9 cycles, then `done`.
  - Frames repeat every 11 cycles.

Source files
------------

// File: rtl/nibble_shift_pkg.sv
// Shared types and defaults for the nibble_shift_out serial readout engine.
package nibble_shift_pkg;

    localparam int unsigned NIBBLE_W        = 4;
    localparam int unsigned NIBBLES_DEFAULT = 4;
    localparam int unsigned DIV_DEFAULT     = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        LATCH,
        DONE
    } state_t;

endpackage

// File: rtl/nibble_shift_out_if.sv
// Request/serial-output bundle for nibble_shift_out; master = requester, slave = engine.
interface nibble_shift_out_if
    import nibble_shift_pkg::*;
#(
    parameter int unsigned NIBBLES = NIBBLES_DEFAULT
);

    logic                          start;
    logic [NIBBLE_W*NIBBLES-1:0]   data_in;
    logic                          busy;
    logic                          done;
    logic                          sclk;
    logic                          sdat;
    logic                          slatch;

    modport master (
        output start, data_in,
        input  busy, done, sclk, sdat, slatch
    );

    modport slave (
        input  start, data_in,
        output busy, done, sclk, sdat, slatch
    );

endinterface

// File: rtl/nibble_shift_out_sclk_divider.sv
// Phase timer: tick marks the last cycle of each DIV-cycle sclk phase.
module sclk_divider
    import nibble_shift_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = $clog2(DIV + 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == W'(DIV - 1));

    // Wrapping on tick restarts the count at every phase change.
    always_ff @(posedge clk) begin
        if (rst || !en || tick)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/nibble_shift_out.sv
// Captures NIBBLES 4-bit digits and shifts them out on sclk/sdat/slatch.
// Define NIBBLE_SHIFT_LSB_FIRST_EN to send bit 0 first (default: MSB first).
module nibble_shift_out
    import nibble_shift_pkg::*;
#(
    parameter int unsigned NIBBLES = NIBBLES_DEFAULT,
    parameter int unsigned DIV     = DIV_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    nibble_shift_out_if.slave  bus
);

    localparam int unsigned B   = NIBBLE_W * NIBBLES;
    localparam int unsigned BCW = $clog2(B + 1);

    state_t          state;
    logic [B-1:0]    sreg;
    logic [BCW-1:0]  bitcnt;
    logic            busy_r;
    logic            done_r;
    logic            sclk_r;
    logic            slatch_r;
    logic            tick;

    sclk_divider #(.DIV(DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (busy_r),
        .tick (tick)
    );

    // sdat is taken straight from the outgoing end of the shift register;
    // clearing sreg on entry to LATCH forces sdat low there and in IDLE.
`ifdef NIBBLE_SHIFT_LSB_FIRST_EN
    assign bus.sdat = sreg[0];
`else
    assign bus.sdat = sreg[B-1];
`endif

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.sclk   = sclk_r;
    assign bus.slatch = slatch_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sreg     <= '0;
            bitcnt   <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            sclk_r   <= 1'b0;
            slatch_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        sreg   <= bus.data_in;
                        bitcnt <= BCW'(B);
                        busy_r <= 1'b1;
                        sclk_r <= 1'b0;
                        state  <= LOW;
                    end
                end
                LOW: begin
                    if (tick) begin
                        sclk_r <= 1'b1;
                        state  <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        bitcnt <= bitcnt - BCW'(1);
                        sclk_r <= 1'b0;
                        if (bitcnt != BCW'(1)) begin
`ifdef NIBBLE_SHIFT_LSB_FIRST_EN
                            sreg <= sreg >> 1;
`else
                            sreg <= sreg << 1;
`endif
                            state <= LOW;
                        end else begin
                            sreg     <= '0;
                            slatch_r <= 1'b1;
                            state    <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        slatch_r <= 1'b0;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_shift_out.sv
// Bench for nibble_shift_out: two instances (4 nibbles/DIV 2 and 1 nibble/DIV 1)
// checked every cycle against a frame-position model plus literal frame expectations.
module tb_nibble_shift_out;

    localparam int TOT_A = 2 * (2 * 16 + 1);
    localparam int TOT_B = 1 * (2 * 4 + 1);

`ifdef NIBBLE_SHIFT_LSB_FIRST_EN
    localparam logic [15:0] EXP_A5C3 = 16'hC3A5;
    localparam logic [15:0] EXP_0001 = 16'h8000;
    localparam bit          LSB      = 1'b1;
`else
    localparam logic [15:0] EXP_A5C3 = 16'hA5C3;
    localparam logic [15:0] EXP_0001 = 16'h0001;
    localparam bit          LSB      = 1'b0;
`endif

    logic clk;
    logic rst;
    logic chk_en;
    int   total;
    int   bad;

    nibble_shift_out_if #(.NIBBLES(4)) a ();
    nibble_shift_out_if #(.NIBBLES(1)) b ();

    nibble_shift_out #(.NIBBLES(4), .DIV(2)) dut_a (.clk(clk), .rst(rst), .bus(a));
    nibble_shift_out #(.NIBBLES(1), .DIV(1)) dut_b (.clk(clk), .rst(rst), .bus(b));

    logic [4:0] outs_a;
    logic [4:0] outs_b;
    assign outs_a = {a.busy, a.done, a.sclk, a.sdat, a.slatch};
    assign outs_b = {b.busy, b.done, b.sclk, b.sdat, b.slatch};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected {busy,done,sclk,sdat,slatch} at position pos of a frame (pos<0 = idle).
    function automatic logic [4:0] ref_out(input int pos, input logic [31:0] w,
                                           input int nb, input int dv);
        int bits;
        int tot;
        int idx;
        int bp;
        logic hi;
        bits = 4 * nb;
        tot  = dv * (2 * bits + 1);
        if (pos < 0) return 5'b00000;
        if (pos == tot) return 5'b01000;
        if (pos >= 2 * dv * bits) return 5'b10001;
        idx = pos / (2 * dv);
        hi  = (pos % (2 * dv)) >= dv;
        bp  = LSB ? idx : bits - 1 - idx;
        return {1'b1, 1'b0, hi, w[bp], 1'b0};
    endfunction

    function automatic logic [15:0] rev16(input logic [15:0] d);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = d[15 - i];
        return r;
    endfunction

    int          pa;
    int          pb;
    logic [31:0] wa;
    logic [31:0] wb;

    always @(posedge clk) begin
        if (rst) begin
            pa <= -1;
            pb <= -1;
        end else begin
            if (pa < 0) begin
                if (a.start) begin
                    pa <= 0;
                    wa <= 32'(a.data_in);
                end
            end else begin
                pa <= (pa >= TOT_A) ? -1 : pa + 1;
            end
            if (pb < 0) begin
                if (b.start) begin
                    pb <= 0;
                    wb <= 32'(b.data_in);
                end
            end else begin
                pb <= (pb >= TOT_B) ? -1 : pb + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_outs", 32'(outs_a), 32'(ref_out(pa, wa, 4, 2)));
            check("b_outs", 32'(outs_b), 32'(ref_out(pb, wb, 1, 1)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame on instance a, observing 100 cycles from the accepting edge.
    // ps/pd/pr: cycle at which to re-pulse start, overwrite data_in, pulse rst (0 = none).
    task automatic run_frame(input logic [15:0] d, input int ps, input int pd, input int pr,
                             output logic [15:0] cap, output int nbusy, output int nlat,
                             output int ndone, output int done_at);
        logic prev;
        a.data_in = d;
        a.start   = 1'b1;
        @(posedge clk);
        #1;
        a.start = 1'b0;
        cap = '0; nbusy = 0; nlat = 0; ndone = 0; done_at = 0; prev = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (a.busy) nbusy++;
            if (a.slatch) nlat++;
            if (a.done) begin
                ndone++;
                if (done_at == 0) done_at = n;
            end
            if (a.sclk && !prev) cap = {cap[14:0], a.sdat};
            prev = a.sclk;
            if (pr != 0 && n == pr + 1) check("rst_mid_outs", 32'(outs_a), 32'd0);
            if (n == ps) a.start = 1'b1;
            if (n == ps + 1) a.start = 1'b0;
            if (n == pd) a.data_in = 16'hFFFF;
            if (n == pr) rst = 1'b1;
            if (n == pr + 1) rst = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [15:0] cap;
        int nbusy, nlat, ndone, done_at;
        logic [3:0] cap4;
        logic prev;
        int nb, nd, last_done;

        total = 0; bad = 0; chk_en = 1'b0;
        rst = 1'b1;
        a.start = 1'b0; a.data_in = '0;
        b.start = 1'b0; b.data_in = '0;
        step();
        chk_en = 1'b1;
        step();
        check("reset_a", 32'(outs_a), 32'd0);
        check("reset_b", 32'(outs_b), 32'd0);
        rst = 1'b0;
        repeat (10) step();
        check("idle_a", 32'(outs_a), 32'd0);
        check("idle_b", 32'(outs_b), 32'd0);

        run_frame(16'hA5C3, 0, 0, 0, cap, nbusy, nlat, ndone, done_at);
        check("a5c3_bits", 32'(cap), 32'(EXP_A5C3));
        check("a5c3_busy", 32'(nbusy), 32'd66);
        check("a5c3_slatch", 32'(nlat), 32'd2);
        check("a5c3_done_at", 32'(done_at), 32'd67);
        check("a5c3_ndone", 32'(ndone), 32'd1);

        run_frame(16'h3C5A, 20, 0, 0, cap, nbusy, nlat, ndone, done_at);
        check("restart_bits", 32'(cap), 32'(LSB ? rev16(16'h3C5A) : 16'h3C5A));
        check("restart_ndone", 32'(ndone), 32'd1);
        check("restart_busy", 32'(nbusy), 32'd66);

        run_frame(16'hA5C3, 0, 10, 0, cap, nbusy, nlat, ndone, done_at);
        check("isolate_bits", 32'(cap), 32'(EXP_A5C3));

        run_frame(16'h1234, 0, 0, 30, cap, nbusy, nlat, ndone, done_at);
        check("rst_mid_slatch", 32'(nlat), 32'd0);
        check("rst_mid_ndone", 32'(ndone), 32'd0);
        check("rst_mid_busy", 32'(nbusy), 32'd30);

        run_frame(16'h0001, 0, 0, 0, cap, nbusy, nlat, ndone, done_at);
        check("after_rst_bits", 32'(cap), 32'(EXP_0001));
        check("after_rst_ndone", 32'(ndone), 32'd1);

        for (int i = 0; i < 1500; i++) begin
            a.start   = ($urandom_range(0, 3) == 0);
            a.data_in = 16'($urandom);
            b.start   = ($urandom_range(0, 2) == 0);
            b.data_in = 4'($urandom);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; a.start = 1'b0; b.start = 1'b0;
        repeat (80) step();

        b.data_in = 4'h9;
        b.start   = 1'b1;
        cap4 = '0; prev = 1'b0; nb = 0; nd = 0; last_done = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (b.busy) nb++;
            if (b.sclk && !prev) cap4 = {cap4[2:0], b.sdat};
            prev = b.sclk;
            if (b.done) begin
                nd++;
                check("min_busy", 32'(nb), 32'd9);
                check("min_bits", 32'(cap4), 32'h9);
                if (last_done != 0) check("min_period", 32'(n - last_done), 32'd11);
                last_done = n;
                nb = 0;
                cap4 = '0;
            end
        end
        check("min_nframes", 32'(nd), 32'd4);
        b.start = 1'b0;
        repeat (15) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
